// File: rtl/bnn_pkg.sv
// bnn_pkg -- shared definitions for the BNN core output path.
//   * bit positions of the fields bnn_out_unit decodes in the 17-bit controller word
//   * default accumulator and packed-word widths
//   * the 2-bit pooling-window quadrant index type
package bnn_pkg;

    localparam int CTRL_W      = 17;
    localparam int CTRL_EMPT   = 0;   // clear packing and pooling state
    localparam int CTRL_SEL_HI = 6;   // store mode (1 = peek) / quadrant select high bit
    localparam int CTRL_OUT    = 10;  // binarize acc_in this cycle
    localparam int CTRL_POOL   = 12;  // route the bit through the 2x2 max-pool window
    localparam int CTRL_SEL_LO = 13;  // quadrant select low bit
    localparam int CTRL_STORE  = 14;  // controller is writing sram_d to the data SRAM

    localparam int DEF_ACC_W   = 16;
    localparam int DEF_WORD_W  = 16;
    localparam int CNT_W       = 5;   // holds 0..16

    typedef logic [1:0] quad_t;

    // A non-negative sum (zero included) becomes a 1.
    function automatic logic binarize(input logic sign_bit);
        return ~sign_bit;
    endfunction

endpackage

// File: rtl/bnn_pool_window.sv
// bnn_pool_window -- 2x2 max-pool window for binary activations.
// The value of a binary max-pool is the OR of its four inputs.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_clr            synchronous clear of all values and flags (EMPT)
//   i_wr             write i_bit into quadrant i_q this cycle
//   i_q, i_bit       quadrant index and binary value
//   o_pooled_bit     OR of all four values, including the incoming one
//   o_pooled_valid   this write fills the last empty quadrant; flags clear at the edge
//   o_busy           at least one quadrant is filled
module bnn_pool_window
    import bnn_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_clr,
    input  logic  i_wr,
    input  quad_t i_q,
    input  logic  i_bit,
    output logic  o_pooled_bit,
    output logic  o_pooled_valid,
    output logic  o_busy
);

    logic [3:0] r_win;
    logic [3:0] r_flag;
    logic [3:0] w_sel;
    logic [3:0] w_win_next;
    logic [3:0] w_flag_next;

    // Post-write view of the window; the pooled result must include the
    // incoming bit, and rewriting a filled quadrant replaces its value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sel       = 4'b0001 << i_q;
        w_win_next  = r_win;
        w_flag_next = r_flag;
        if (i_wr) begin
            w_win_next  = (r_win & ~w_sel) | (w_sel & {4{i_bit}});
            w_flag_next = r_flag | w_sel;
        end
    end

    assign o_pooled_valid = i_wr && (w_flag_next == 4'hF);
    assign o_pooled_bit   = |w_win_next;
    assign o_busy         = |r_flag;

    // NOTE: the four value bits are reset like ordinary state: a small register
    // file, not a RAM, and the flags alone decide which values are meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples the pre-edge values regardless of statement order.
            r_win  <= '0;
            r_flag <= '0;
        end else if (i_clr) begin
            r_win  <= '0;
            r_flag <= '0;
        end else if (i_wr) begin
            r_win  <= w_win_next;
            r_flag <= o_pooled_valid ? 4'h0 : w_flag_next;
        end
    end

endmodule

// File: rtl/bnn_out_unit.sv
// bnn_out_unit -- binarize BPU sums, optionally 2x2 max-pool them, and pack
// the bits into a word that is written to the data SRAM on a store.
// Optional feature macro: BNN_POOL_EN (instantiates bnn_pool_window; when
// undefined, ctrl[12] is ignored and pool_busy is tied low).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bnncore_ctrl   controller word; bits EMPT/SEL_HI/OUT/POOL/SEL_LO/STORE used
//   acc_in         signed column sum, sampled when ctrl[10] is set
//   sram_d         packing register, right-justified, newest bit in bit 0
//   bit_cnt        bits packed into the current word (0..WORD_W)
//   word_full      bit_cnt == WORD_W
//   pool_busy      pooling window partially filled
//   ovf            sticky: a bit was dropped because the word was full
module bnn_out_unit
    import bnn_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CTRL_W-1:0]       bnncore_ctrl,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic [WORD_W-1:0]       sram_d,
    output logic [CNT_W-1:0]        bit_cnt,
    output logic                    word_full,
    output logic                    pool_busy,
    output logic                    ovf
);

    logic [WORD_W-1:0] r_res;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;

    logic w_empt;
    logic w_store;
    logic w_out;
    logic w_bin;
    logic w_pack_req;
    logic w_pack_bit;
    logic w_full;
    logic w_unused;

    // Command priority: EMPT > store > bnn_out.
    assign w_empt  = bnncore_ctrl[CTRL_EMPT];
    assign w_store = bnncore_ctrl[CTRL_STORE] & ~w_empt;
    assign w_out   = bnncore_ctrl[CTRL_OUT] & ~w_empt & ~bnncore_ctrl[CTRL_STORE];
    assign w_bin   = binarize(acc_in[ACC_W-1]);
    assign w_full  = (r_cnt == CNT_W'(WORD_W));

    // Only the sign of acc_in and a few control bits matter here.
    assign w_unused = ^{bnncore_ctrl, acc_in};

`ifdef BNN_POOL_EN
    logic  w_pool_wr;
    logic  w_pooled_bit;
    logic  w_pooled_valid;
    logic  w_pool_busy;
    quad_t w_quad;

    assign w_pool_wr = w_out & bnncore_ctrl[CTRL_POOL];
    assign w_quad    = {bnncore_ctrl[CTRL_SEL_HI], bnncore_ctrl[CTRL_SEL_LO]};

    bnn_pool_window u_pool (
        .clk            (clk),
        .rst            (rst),
        .i_clr          (w_empt),
        .i_wr           (w_pool_wr),
        .i_q            (w_quad),
        .i_bit          (w_bin),
        .o_pooled_bit   (w_pooled_bit),
        .o_pooled_valid (w_pooled_valid),
        .o_busy         (w_pool_busy)
    );

    // A pooled bit is packed only on the write that completes the window.
    assign w_pack_req = (w_out & ~bnncore_ctrl[CTRL_POOL]) | w_pooled_valid;
    assign w_pack_bit = bnncore_ctrl[CTRL_POOL] ? w_pooled_bit : w_bin;
    assign pool_busy  = w_pool_busy;
`else
    assign w_pack_req = w_out;
    assign w_pack_bit = w_bin;
    assign pool_busy  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_empt) begin
            r_res <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_store) begin
            // The SRAM samples sram_d on this same edge, so clearing here still
            // writes the old word. SEL_HI set means peek: keep the word.
            if (!bnncore_ctrl[CTRL_SEL_HI]) begin
                r_res <= '0;
                r_cnt <= '0;
            end
        end else if (w_pack_req) begin
            if (!w_full) begin
                r_res <= {r_res[WORD_W-2:0], w_pack_bit};
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign sram_d    = r_res;
    assign bit_cnt   = r_cnt;
    assign word_full = w_full;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bnn_out_unit.sv
// tb_bnn_out_unit -- directed self-checking bench for bnn_out_unit.
// Expected observations are queued as each step is driven and popped when
// the DUT outputs are sampled 1 time unit after the clock edge.
// Pooling steps run when BNN_POOL_EN is defined; otherwise the bench checks
// that ctrl[12] is ignored.
module tb_bnn_out_unit;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  cnt;
        logic        full;
        logic        busy;
        logic        ovf;
    } obs_t;

    localparam logic [16:0] C_EMPT   = 17'h00001;
    localparam logic [16:0] C_SEL_HI = 17'h00040;
    localparam logic [16:0] C_OUT    = 17'h00400;
    localparam logic [16:0] C_POOL   = 17'h01000;
    localparam logic [16:0] C_SEL_LO = 17'h02000;
    localparam logic [16:0] C_STORE  = 17'h04000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [16:0]        bnncore_ctrl = '0;
    logic signed [15:0] acc_in = '0;
    logic [15:0]        sram_d;
    logic [4:0]         bit_cnt;
    logic               word_full;
    logic               pool_busy;
    logic               ovf;

    obs_t  q_exp[$];
    string q_tag[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    bnn_out_unit dut (
        .clk          (clk),
        .rst          (rst),
        .bnncore_ctrl (bnncore_ctrl),
        .acc_in       (acc_in),
        .sram_d       (sram_d),
        .bit_cnt      (bit_cnt),
        .word_full    (word_full),
        .pool_busy    (pool_busy),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [15:0] d, input int cnt,
                                input logic ovf_e, input logic busy_e);
        obs_t o;
        o.d    = d;
        o.cnt  = cnt[4:0];
        o.full = (cnt == 16);
        o.busy = busy_e;
        o.ovf  = ovf_e;
        return o;
    endfunction

    task automatic expect_obs(input obs_t e, input string tag);
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    // Pops the oldest expectation and compares it with the current outputs.
    task automatic check();
        obs_t  got;
        obs_t  e;
        string tag;
        got = {sram_d, bit_cnt, word_full, pool_busy, ovf};
        e   = q_exp.pop_front();
        tag = q_tag.pop_front();
        n_cmp++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: got d=%h cnt=%0d full=%b busy=%b ovf=%b, want d=%h cnt=%0d full=%b busy=%b ovf=%b",
                   tag, got.d, got.cnt, got.full, got.busy, got.ovf,
                   e.d, e.cnt, e.full, e.busy, e.ovf);
        end
    endtask

    // One clocked step; optionally also checks the outputs while the command
    // is held, before the edge (the value the SRAM would sample).
    task automatic step(input logic [16:0] ctrl, input logic signed [15:0] acc,
                        input obs_t e, input string tag,
                        input bit has_pre = 1'b0, input obs_t pre_e = '0);
        bnncore_ctrl = ctrl;
        acc_in       = acc;
        if (has_pre) begin
            expect_obs(pre_e, {tag, "_pre"});
            #1;
            check();
        end
        expect_obs(e, tag);
        @(posedge clk);
        #1;
        bnncore_ctrl = '0;
        check();
    endtask

    initial begin
        logic [15:0] exp_d;

        // Reset state
        #3;
        expect_obs(mk(16'h0000, 0, 0, 0), "reset");
        check();
        @(negedge clk);
        rst = 1'b0;

        // 16 direct bits, alternating +5 / -3 -> 1,0,1,0,...
        exp_d = '0;
        for (int i = 0; i < 16; i++) begin
            exp_d = {exp_d[14:0], (i % 2 == 0)};
            step(C_OUT, (i % 2 == 0) ? 16'sd5 : -16'sd3, mk(exp_d, i + 1, 0, 0), "direct_fill");
        end
        expect_obs(mk(16'hAAAA, 16, 0, 0), "word_aaaa");
        check();

        // 17th bit (acc=0 -> 1) is dropped, ovf sets
        step(C_OUT, 16'sd0, mk(16'hAAAA, 16, 1, 0), "overflow");
        step(C_EMPT, 16'sd0, mk(16'h0000, 0, 0, 0), "empt");

        // 1,0,1 then clearing store: SRAM sees 0x0005
        step(C_OUT, 16'sd3, mk(16'h0001, 1, 0, 0), "bits_a");
        step(C_OUT, -16'sd1, mk(16'h0002, 2, 0, 0), "bits_b");
        step(C_OUT, 16'sd0, mk(16'h0005, 3, 0, 0), "bits_c");
        step(C_STORE, 16'sd0, mk(16'h0000, 0, 0, 0), "store_clr", 1'b1, mk(16'h0005, 3, 0, 0));
        step(C_OUT, 16'sd9, mk(16'h0001, 1, 0, 0), "b2b_after_store");

        // Store beats a same-cycle bnn_out
        step(C_STORE | C_OUT, 16'sd9, mk(16'h0000, 0, 0, 0), "store_wins");

        // Peek store keeps state, also when bnn_out is set with it
        step(C_OUT, 16'sd1, mk(16'h0001, 1, 0, 0), "peek_setup_a");
        step(C_OUT, 16'sd1, mk(16'h0003, 2, 0, 0), "peek_setup_b");
        step(C_STORE | C_SEL_HI, 16'sd0, mk(16'h0003, 2, 0, 0), "peek");
        step(C_STORE | C_SEL_HI | C_OUT, -16'sd4, mk(16'h0003, 2, 0, 0), "peek_drops_out");

        // EMPT beats store and bnn_out
        step(C_EMPT | C_STORE | C_OUT, 16'sd5, mk(16'h0000, 0, 0, 0), "empt_wins");

`ifdef BNN_POOL_EN
        // Window -1,-1,7,-1 -> pooled 1
        step(C_OUT | C_POOL, -16'sd1, mk(16'h0000, 0, 0, 1), "pool_q0");
        step(C_OUT | C_POOL | C_SEL_LO, -16'sd1, mk(16'h0000, 0, 0, 1), "pool_q1");
        step(C_OUT | C_POOL | C_SEL_HI, 16'sd7, mk(16'h0000, 0, 0, 1), "pool_q2");
        step(C_OUT | C_POOL | C_SEL_HI | C_SEL_LO, -16'sd1, mk(16'h0001, 1, 0, 0), "pool_one");

        // Window of all -1 -> pooled 0
        step(C_OUT | C_POOL, -16'sd1, mk(16'h0001, 1, 0, 1), "pool0_q0");
        step(C_OUT | C_POOL | C_SEL_LO, -16'sd1, mk(16'h0001, 1, 0, 1), "pool0_q1");
        step(C_OUT | C_POOL | C_SEL_HI, -16'sd1, mk(16'h0001, 1, 0, 1), "pool0_q2");
        step(C_OUT | C_POOL | C_SEL_HI | C_SEL_LO, -16'sd1, mk(16'h0002, 2, 0, 0), "pool_zero");

        // Rewriting q0 with -1 replaces the earlier 1 -> pooled 0
        step(C_OUT | C_POOL, 16'sd1, mk(16'h0002, 2, 0, 1), "ovw_q0_hi");
        step(C_OUT | C_POOL, -16'sd1, mk(16'h0002, 2, 0, 1), "ovw_q0_lo");
        step(C_OUT | C_POOL | C_SEL_LO, -16'sd1, mk(16'h0002, 2, 0, 1), "ovw_q1");
        step(C_OUT | C_POOL | C_SEL_HI, -16'sd1, mk(16'h0002, 2, 0, 1), "ovw_q2");
        step(C_OUT | C_POOL | C_SEL_HI | C_SEL_LO, -16'sd1, mk(16'h0004, 3, 0, 0), "ovw_result");

        // Two quadrants filled, then asynchronous reset
        step(C_OUT | C_POOL, -16'sd1, mk(16'h0004, 3, 0, 1), "mid_q0");
        step(C_OUT | C_POOL | C_SEL_LO, -16'sd1, mk(16'h0004, 3, 0, 1), "mid_q1");
`else
        // ctrl[12] ignored: every bnn_out packs directly
        step(C_OUT | C_POOL, -16'sd1, mk(16'h0000, 1, 0, 0), "nopool_a");
        step(C_OUT | C_POOL | C_SEL_HI | C_SEL_LO, 16'sd5, mk(16'h0001, 2, 0, 0), "nopool_b");
`endif

        // Asynchronous reset between clock edges clears state at once
        #2;
        rst = 1'b1;
        #1;
        expect_obs(mk(16'h0000, 0, 0, 0), "async_reset");
        check();
        @(negedge clk);
        rst = 1'b0;
        step(C_OUT, 16'sd2, mk(16'h0001, 1, 0, 0), "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_out_unit.md
# bnn_out_unit

Binarization and output-packing stage inside the BNN core, directly downstream of the BNN controller. It consumes the 17-bit core control word and the signed partial-sum from the BPU column adder. It turns each sum into one binary activation, optionally 2x2 max-pools it, packs the results into a 16-bit word, and presents that word as write data to the data SRAM when the controller issues a store.

## Interface
- ACC_W, 16, width of the signed accumulator input
- WORD_W, 16, packed output word width (data SRAM width)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- bnncore_ctrl  in  17  registered control word from the BNN controller
  - [0] EMPT
  - [6] store mode / pool-select high bit
  - [10] bnn_out
  - [12] pool enable
  - [13] pool-select low bit
  - [14] store
  - all other bits are ignored by this block
- acc_in  in  ACC_W  signed sum from the BPU column adder, valid while bnncore_ctrl[10]=1
- sram_d  out  WORD_W  write data to the data SRAM; a direct view of the packing register
- bit_cnt  out  5  number of bits packed into the current word, 0..16
- word_full  out  1  bit_cnt==16
- pool_busy  out  1  at least one 2x2 window quadrant is filled
- ovf  out  1  sticky: a bit was dropped because the word was full

## Operation
- Binarize: bit = ~acc_in[ACC_W-1], i.e. 1 when acc_in ≥ 0. Zero maps to 1.
- Priority when several command bits are set in one cycle: EMPT > store > bnn_out. A lower-priority command in the same cycle is ignored.
- EMPT (ctrl[0]): clear res_reg, bit_cnt, all window quadrants and flags, and ovf.
- bnn_out direct (ctrl[10]=1, ctrl[12]=0):
  - if bit_cnt<16: res_reg <= {res_reg[14:0], bit}; bit_cnt++.
  - if bit_cnt==16: the bit is dropped and ovf is set.
- bnn_out pooled (ctrl[10]=1, ctrl[12]=1):
  - q = {ctrl[6], ctrl[13]}; win[q] <= bit; flag[q] <= 1.
  - Rewriting an already-filled quadrant overwrites its value.
  - When the write fills the last empty quadrant, the pooled bit = OR of all four values (including the incoming one). It is packed into res_reg under the same full/ovf rule as the direct path, and all flags clear in that same edge.
- Store (ctrl[14]):
  - ctrl[6]=0: res_reg and bit_cnt clear at the next edge.
  - ctrl[6]=1: peek; the state is kept.
  - Window state is unaffected in both modes.
- sram_d = res_reg, combinational from state, so it is always stable during the cycle the controller drives the SRAM address/CEN/WEN.
- A partially filled word is stored as is: bits are right-justified, upper bits are 0.

## Timing
- Reset values: sram_d=0, bit_cnt=0, word_full=0, pool_busy=0, ovf=0; all windows and flags are 0.
- bnn_out latency: 1 cycle. The packed bit is visible on sram_d/bit_cnt in the cycle after ctrl[10].
- Store: the controller asserts ctrl[14] and the SRAM control in the same cycle t. The SRAM samples sram_d at edge t+1, and the clear also happens at edge t+1, so the old word is written.
- A bnn_out issued at cycle t+1 (back-to-back after a clearing store) lands in bit position 0 of the new word.
- Asynchronous reset mid-operation discards a partial word and partial windows immediately. There is no pending-write recovery.
- No handshake back-pressure exists: the controller program guarantees ordering, and ovf flags violations.

## Configuration
- BNN_POOL_EN defined: window registers, flags and pool_busy logic are present.
- BNN_POOL_EN undefined:
  - ctrl[12] is ignored and every bnn_out takes the direct path.
  - pool_busy is tied to 0.
  - ctrl[6]/ctrl[13] affect only store mode.

## Structure
- Shared package bnn_pkg holds:
  - control-bit index constants (CTRL_EMPT=0, CTRL_SEL_HI=6, CTRL_OUT=10, CTRL_POOL=12, CTRL_SEL_LO=13, CTRL_STORE=14)
  - ACC_W/WORD_W defaults
  - the 2-bit quadrant type
- One sub-module, bnn_pool_window:
  - contains the 4 value bits and 4 flags
  - outputs pooled bit plus pooled_valid and busy
  - instantiated only under BNN_POOL_EN

## Test plan
- Reset, then 16 direct bnn_out with acc_in alternating +5/−3 -> sram_d=16'hAAAA, bit_cnt=16, word_full=1, ovf=0.
- 17th direct bnn_out with acc_in=0 -> sram_d unchanged at 16'hAAAA, ovf=1. EMPT -> all outputs 0.
- 3 direct bits 1,0,1, then store with ctrl[6]=0 -> SRAM receives 16'h0005. The next cycle shows bit_cnt=0, and a bnn_out in that cycle gives bit_cnt=1.
- Pooled writes q=0..3 with acc_in −1,−1,7,−1 -> pool_busy=1 after the first write, pooled bit 1 packed after the 4th write, pool_busy=0. Quadrants −1×4 give a packed 0.
- Same-cycle ctrl[14]|ctrl[10] with ctrl[6]=0 -> store wins, the bit is dropped, bit_cnt=0. Store with ctrl[6]=1 -> sram_d and bit_cnt are retained.
- Assert rst asynchronously mid-window (2 quadrants filled) -> pool_busy, bit_cnt and sram_d go to 0 without waiting for a clock edge.
